// File: rtl/viterbi_pkg.sv
// Shared Viterbi datapath definitions: constraint length, default generators,
// trellis state type, encoder FSM states and the branch parity function.
package viterbi_pkg;

    localparam int K = 3;
    localparam logic [K-1:0] G0_DEF = 3'b111;
    localparam logic [K-1:0] G1_DEF = 3'b101;

    typedef logic [K-2:0] trellis_t;

    typedef enum logic [1:0] {
        DATA  = 2'd0,
        TAIL1 = 2'd1,
        TAIL2 = 2'd2
    } enc_state_t;

    // Generator bit2 taps u, bit1 taps s1, bit0 taps s0.
    function automatic logic enc_parity(input logic [K-1:0] g, input logic u, input trellis_t sr);
        return ^(g & {u, sr});
    endfunction

endpackage

// File: rtl/conv_encoder.sv
// Rate-1/2 K=3 convolutional encoder with valid/ready on both sides and
// optional zero-termination of each frame with two tail symbols.
module conv_encoder
    import viterbi_pkg::*;
#(
    parameter logic [K-1:0] G0        = G0_DEF,
    parameter logic [K-1:0] G1        = G1_DEF,
    parameter bit           TERMINATE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_bit,
    input  logic in_last,
    output logic out_valid,
    input  logic out_ready,
    output logic cx0,
    output logic cx1,
    output logic out_tail,
    output logic out_last
);

    enc_state_t r_state;
    enc_state_t w_next;
    trellis_t   r_sr;
    logic       r_out_valid;
    logic       r_cx0;
    logic       r_cx1;
    logic       r_tail;
    logic       r_last;

    logic       w_load;
    logic       w_accept;
    logic       w_emit;
    logic       w_u;
    logic       w_tail;
    logic       w_last;

    // The output register may be refilled when empty or being drained.
    assign w_load = !r_out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DATA;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            DATA:    if (w_accept && in_last && TERMINATE) w_next = TAIL1;
            TAIL1:   if (w_load) w_next = TAIL2;
            TAIL2:   if (w_load) w_next = DATA;
            default: w_next = DATA;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        w_accept = 1'b0;
        w_emit   = 1'b0;
        w_u      = 1'b0;
        w_tail   = 1'b0;
        w_last   = 1'b0;
        case (r_state)
            DATA: begin
                in_ready = w_load;
                w_accept = in_valid && w_load;
                w_emit   = w_accept;
                w_u      = in_bit;
                w_last   = in_last && !TERMINATE;
            end
            TAIL1: begin
                w_emit = w_load;
                w_tail = 1'b1;
            end
            TAIL2: begin
                w_emit = w_load;
                w_tail = 1'b1;
                w_last = 1'b1;
            end
            default: ;
        endcase
    end

    // Two zero tail inputs flush sr back to 00 without any explicit clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr        <= '0;
            r_out_valid <= 1'b0;
            r_cx0       <= 1'b0;
            r_cx1       <= 1'b0;
            r_tail      <= 1'b0;
            r_last      <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= w_emit;
            if (w_emit) begin
                r_cx0  <= enc_parity(G0, w_u, r_sr);
                r_cx1  <= enc_parity(G1, w_u, r_sr);
                r_tail <= w_tail;
                r_last <= w_last;
                r_sr   <= {w_u, r_sr[1]};
            end
        end
    end

    assign out_valid = r_out_valid;
    assign cx0       = r_cx0;
    assign cx1       = r_cx1;
    assign out_tail  = r_tail;
    assign out_last  = r_last;

endmodule
